note_scheduler: RTL

NOTE_SCHEDULER -- requirements
Module: note_scheduler

---
 rtl/note_pkg.sv | 41 ++++
 rtl/lfsr13.sv | 28 ++
 rtl/note_scheduler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/note_pkg.sv
// Shared types and constants for the note scheduler: FSM states, lane masks and LFSR seed.
package note_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StPaused,
    StDraw,
    StEmit,
    StDone
  } state_e;

  localparam logic [4:0] LANE_G    = 5'b10000;
  localparam logic [4:0] LANE_R    = 5'b01000;
  localparam logic [4:0] LANE_Y    = 5'b00100;
  localparam logic [4:0] LANE_B    = 5'b00010;
  localparam logic [4:0] LANE_O    = 5'b00001;
  localparam logic [4:0] LANE_NONE = 5'b00000;

  localparam logic [12:0] LFSR_SEED = 13'h0001;

  // Draw values 5..7 are rests and map to no lane.
  function automatic logic [4:0] map_draw(input logic [2:0] draw);
    logic [4:0] lane;
    case (draw)
      3'd0:    lane = LANE_G;
      3'd1:    lane = LANE_R;
      3'd2:    lane = LANE_Y;
      3'd3:    lane = LANE_B;
      3'd4:    lane = LANE_O;
      default: lane = LANE_NONE;
    endcase
    return lane;
  endfunction

  // g->r->y->b->o->g is a rotate right of the one-hot mask.
  function automatic logic [4:0] next_lane(input logic [4:0] lane);
    return {lane[0], lane[4:1]};
  endfunction

endpackage

// File: rtl/lfsr13.sv
// 13-bit Fibonacci LFSR, shift left, taps 12/3/2/0; free-runs every clock.
module lfsr13
  import note_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [12:0] o_lfsr
);

  logic [12:0] r_lfsr;
  logic        w_fb;

  assign w_fb = r_lfsr[12] ^ r_lfsr[3] ^ r_lfsr[2] ^ r_lfsr[0];

  // The all-zero lock-up state is unreachable from the seed; reseed defensively anyway.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (r_lfsr == '0) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[11:0], w_fb};
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/note_scheduler.sv
// Beat-timed note scheduler: draws a pseudo-random lane each beat and presents it on a
// valid/ready output with anti-repeat substitution and sticky overflow tracking.
module note_scheduler
  import note_pkg::*;
#(
  parameter logic [15:0] BEAT_DIV   = 16'd50000,
  parameter logic [7:0]  SONG_BEATS = 8'd128,
  parameter logic [1:0]  MAX_REPEAT = 2'd2
) (
  input  logic       Clk,
  input  logic       RESET_N,
  input  logic       start,
  input  logic       pause,
  input  logic       note_ready,
  output logic       note_valid,
  output logic [4:0] note_lanes,
  output logic [7:0] beat_count,
  output logic       song_done,
  output logic       overflow
);

  state_e      r_state;
  state_e      w_state_next;
  logic [15:0] r_cnt;
  logic [7:0]  r_beat_count;
  logic [2:0]  r_draw;
  logic [4:0]  r_prev_lane;
  logic [1:0]  r_run_len;
  logic        r_note_valid;
  logic [4:0]  r_note_lanes;
  logic        r_overflow;

  logic [12:0] w_lfsr;
  logic        w_unused_lfsr;
  logic        w_tc;
  logic        w_start;
  logic        w_song_done;
  logic        w_emit_note;
  logic        w_repeat;
  logic        w_sub;
  logic [4:0]  w_mapped;
  logic [4:0]  w_lane;

  lfsr13 u_lfsr (
    .i_clk  (Clk),
    .i_rst_n(RESET_N),
    .o_lfsr (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[12:3];
  assign w_tc          = (r_cnt == BEAT_DIV - 16'd1);
  assign w_start       = start && ((r_state == StIdle) || (r_state == StDone));

  always_ff @(posedge Clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Terminal count wins over pause so a beat is never lost.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone: if (start) w_state_next = StRun;
      StRun: begin
        if (w_tc) begin
          w_state_next = StDraw;
        end else if (pause) begin
          w_state_next = StPaused;
        end
      end
      StPaused: if (!pause) w_state_next = StRun;
      StDraw:   w_state_next = StEmit;
      StEmit:   w_state_next = (r_beat_count == SONG_BEATS) ? StDone : StRun;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_song_done = (r_state == StDone);
    w_mapped    = map_draw(r_draw);
    w_repeat    = (w_mapped == r_prev_lane);
    w_sub       = w_repeat && (r_run_len == MAX_REPEAT);
    w_lane      = w_sub ? next_lane(w_mapped) : w_mapped;
    w_emit_note = (r_state == StEmit) && (w_mapped != LANE_NONE);
  end

  always_ff @(posedge Clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt        <= '0;
      r_beat_count <= '0;
      r_draw       <= '0;
    end else begin
      if (w_start) begin
        r_cnt        <= '0;
        r_beat_count <= '0;
      end else if (r_state == StRun) begin
        if (w_tc) begin
          r_cnt        <= '0;
          r_beat_count <= r_beat_count + 8'd1;
        end else if (!pause) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
      if (r_state == StDraw) begin
        r_draw <= w_lfsr[2:0];
      end
    end
  end

  // Rests leave the repeat tracking untouched; only emitted lanes count toward a run.
  always_ff @(posedge Clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_prev_lane <= LANE_NONE;
      r_run_len   <= '0;
    end else if (w_start) begin
      r_prev_lane <= LANE_NONE;
      r_run_len   <= '0;
    end else if (w_emit_note) begin
      r_prev_lane <= w_lane;
      r_run_len   <= (w_repeat && !w_sub) ? r_run_len + 2'd1 : 2'd1;
    end
  end

  always_ff @(posedge Clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_note_valid <= 1'b0;
      r_note_lanes <= LANE_NONE;
      r_overflow   <= 1'b0;
    end else begin
      if (w_emit_note) begin
        r_note_valid <= 1'b1;
        r_note_lanes <= w_lane;
        if (r_note_valid && !note_ready) begin
          r_overflow <= 1'b1;
        end
      end else if (r_note_valid && note_ready) begin
        r_note_valid <= 1'b0;
      end
      if (w_start) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign note_valid = r_note_valid;
  assign note_lanes = r_note_lanes;
  assign beat_count = r_beat_count;
  assign song_done  = w_song_done;
  assign overflow   = r_overflow;

endmodule
